uart_word_tx: RTL
=================

Name: uart_word_tx

Overview:
- UART transmitter; the outbound counterpart of the board's UART receive path.
- Accepts 32-bit words from the CPU/MMIO side through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word as 4 bytes, least-significant byte first. Each byte is 8N1, LSB-first, on the tx pin.
- Used for debug dumps and program-output streaming back to the host PC.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2.
- FIFO_DEPTH, 4, word entries in the input FIFO; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- data_in  input  32  word to transmit
- valid_in  input  1  data_in valid this cycle
- ready_out  output  1  FIFO can accept a word (= !full)
- tx  output  1  serial line, idle high, registered
- busy  output  1  a frame is in progress or the FIFO is non-empty
- word_done  output  1  one-cycle pulse when the stop bit of byte 3 of a word completes
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, word_done=0, ready_out=1, fifo_level=0, FSM=IDLE, all counters 0.
  - Reset asserted mid-frame abandons the frame; tx returns high immediately.
- Push: a word is written on the rising edge where valid_in && ready_out.
  - ready_out depends only on full. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle while not full: fifo_level unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into a 32-bit shift register, set byte_idx=0, go to START. Otherwise stay.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At expiry:
    - if byte_idx<3: byte_idx++, shift the register right by 8, go to START (no idle gap between bytes);
    - if byte_idx==3: pulse word_done for 1 cycle, then go to IDLE if the FIFO is empty, else pop the next word and go to START directly (no idle gap between words).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
  - Reset to 0 on every state entry from IDLE.
- Latency:
  - FIFO empty, FSM idle, push on edge N: pop on edge N+1, tx falls on edge N+2.
  - Full word duration is 40·CLKS_PER_BIT cycles; word_done is asserted on the edge that ends it.
- busy = (state != IDLE) || (fifo_level != 0).
- Wrap-around: FIFO read/write pointers use an extra MSB for full/empty detection and wrap modulo FIFO_DEPTH.
- data_in is sampled only on an accepting edge; its value at other times is don't-care.

Decomposition:
- Shared package (Const.svh):
  - typedef enum uart_tx_state_t {IDLE, START, DATA, STOP};
  - `UART_CLKS_PER_BIT constant (868);
  - reuse `DATA_WID for the 32-bit word width.
- One sub-module: uart_tx_fifo.
  - Synchronous FIFO, parameterised by width and depth.
  - Same clk and async active-low rst_n.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - uart_word_tx instantiates it and holds the FSM, baud counter, bit/byte counters and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Single word: push 0xA5C3_0F81 → tx carries bytes 0x81, 0x0F, 0xC3, 0xA5, each 0‑start/8 bits LSB-first/1‑stop, 4 cycles per bit. tx falls 2 cycles after the push; word_done pulses once, 160 cycles after tx falls; busy then returns 0.
- Back-to-back: push 0x0000_0001 then 0xFFFF_FFFF on consecutive cycles → 320 contiguous frame cycles with no idle-high gap beyond stop bits; two word_done pulses, 160 cycles apart.
- Full FIFO: hold valid_in high with 6 distinct words while tx is busy → ready_out drops when fifo_level=4; only accepted words appear on tx, in order; no word is lost or duplicated.
- Full plus simultaneous pop: FIFO full, valid_in=1 on the pop cycle → push refused that cycle; accepted on the next cycle; fifo_level goes 4→3→4.
- Reset mid-frame: assert rst_n=0 during bit 3 of byte 1 → tx=1, busy=0, fifo_level=0, ready_out=1 immediately. After release, push 0x55 → a clean frame of 0x55, 0x00, 0x00, 0x00.
- Baud check (CLKS_PER_BIT=868): push 0x0000_0055 → each bit of byte 0 lasts exactly 868 cycles; total word time is 34720 cycles.

Source files
------------

// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the word-oriented UART transmitter.
package uart_word_tx_pkg;

  localparam int DATA_WID          = 32;
  localparam int UART_CLKS_PER_BIT = 868;
  localparam int BYTES_PER_WORD    = DATA_WID / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
module uart_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign level   = wptr_q - rptr_q;
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
    if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_word_tx.sv
// UART transmitter: buffers 32-bit words and sends each as four 8N1 bytes, LSB byte first.
//
// state | meaning
// IDLE  | line high, waiting for a buffered word
// START | start bit (low) of the current byte
// DATA  | data bits of the current byte, LSB first
// STOP  | stop bit (high); chains to next byte or next word
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic                          tx,
  output logic                          busy,
  output logic                          word_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  uart_tx_state_t      state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [1:0]          byte_q, byte_d;
  logic [DATA_WID-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                stop_end_q, stop_end_d;
  logic                word_done_q, word_done_d;

  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_WID-1:0] fifo_rdata;
  logic                tick;

  uart_tx_fifo #(
    .WIDTH (DATA_WID),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (valid_in),
    .pop   (fifo_pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tick      = (baud_q == CNT_MAX);
  assign ready_out = !fifo_full;
  assign tx        = tx_q;
  assign word_done = word_done_q;
  assign busy      = (state_q != IDLE) || (fifo_level != '0);

  always_comb begin
    state_d     = state_q;
    baud_d      = tick ? '0 : baud_q + CNT_W'(1);
    bit_d       = bit_q;
    byte_d      = byte_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    stop_end_d  = 1'b0;
    word_done_d = stop_end_q;
    tx_d        = 1'b1;

    // tx and word_done trail the state by one cycle so the line is a clean flop output.
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          byte_d   = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[bit_q];
        if (tick) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {8'h00, shift_q[DATA_WID-1:8]};
            state_d = START;
          end else begin
            stop_end_d = 1'b1;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rdata;
              byte_d   = '0;
              bit_d    = '0;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      stop_end_q  <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      stop_end_q  <= stop_end_d;
      word_done_q <= word_done_d;
    end
  end

endmodule
